// File: rtl/column_reducer_pkg.sv
// column_reducer_pkg
//   Shared types and defaults for the column reduction stage and any future
//   group-by stages that reuse the reduce step.
//   Contents:
//     NUM_SIZE_DEFAULT - default data width (signed two's complement)
//     LEN_W_DEFAULT    - default element-count width
//     agg_op_t         - reduction operator encoding
//     agg_identity()   - identity value of an operator at a given width
package column_reducer_pkg;

  localparam int NUM_SIZE_DEFAULT = 32;
  localparam int LEN_W_DEFAULT    = 16;

  typedef enum logic [1:0] {
    AGG_SUM = 2'd0,
    AGG_MIN = 2'd1,
    AGG_MAX = 2'd2,
    AGG_CNT = 2'd3
  } agg_op_t;

  // Identities at the default width. MIN starts at the most positive value,
  // MAX at the most negative one.
  localparam logic [NUM_SIZE_DEFAULT-1:0] ID_SUM = '0;
  localparam logic [NUM_SIZE_DEFAULT-1:0] ID_MIN = {1'b0, {(NUM_SIZE_DEFAULT-1){1'b1}}};
  localparam logic [NUM_SIZE_DEFAULT-1:0] ID_MAX = {1'b1, {(NUM_SIZE_DEFAULT-1){1'b0}}};
  localparam logic [NUM_SIZE_DEFAULT-1:0] ID_CNT = '0;

endpackage

// File: rtl/column_reducer_reduce_step.sv
// column_reducer_reduce_step
//   Purely combinational single-element reduction: folds one element into the
//   running accumulator for the selected operator.
//   Ports:
//     acc      in  NUM_SIZE  current accumulator
//     in_data  in  NUM_SIZE  element to fold in
//     op       in  agg_op_t  reduction operator
//     next_acc out NUM_SIZE  updated accumulator
//     ovf      out 1         signed SUM overflow on this step (SUM only)
module column_reducer_reduce_step
  import column_reducer_pkg::*;
#(
  parameter int NUM_SIZE = NUM_SIZE_DEFAULT
) (
  input  logic [NUM_SIZE-1:0] acc,
  input  logic [NUM_SIZE-1:0] in_data,
  input  agg_op_t             op,
  output logic [NUM_SIZE-1:0] next_acc,
  output logic                ovf
);

  logic [NUM_SIZE-1:0] sum;
  logic                in_lt_acc;

  assign sum       = acc + in_data;
  assign in_lt_acc = $signed(in_data) < $signed(acc);

  always_comb begin
    next_acc = acc;
    ovf      = 1'b0;
    case (op)
      AGG_SUM: begin
        next_acc = sum;
        // Same-signed operands producing a result of the other sign.
        ovf = (acc[NUM_SIZE-1] == in_data[NUM_SIZE-1]) &&
              (sum[NUM_SIZE-1] != acc[NUM_SIZE-1]);
      end
      AGG_MIN: next_acc = in_lt_acc ? in_data : acc;
      AGG_MAX: next_acc = in_lt_acc ? acc : in_data;
      AGG_CNT: next_acc = acc + {{(NUM_SIZE-1){1'b0}}, |in_data};
      default: next_acc = acc;
    endcase
  end

endmodule

// File: rtl/column_reducer.sv
// column_reducer
//   Reduces one column of ALU results (in_data <- ALU out, in_valid <- ALU
//   valid) to a scalar: SUM, MIN, MAX or COUNT of non-zero elements. The
//   scalar is held behind a valid/ready handshake until the host accepts it.
//   All outputs are registered; LEN_W must not exceed NUM_SIZE.
//   Ports:
//     clk        in  1         clock
//     reset      in  1         asynchronous active-high reset
//     start      in  1         request; latches agg_op and len (IDLE only)
//     agg_op     in  2         0=SUM 1=MIN 2=MAX 3=COUNT_NZ
//     len        in  LEN_W     elements to reduce
//     in_valid   in  1         element strobe
//     in_data    in  NUM_SIZE  element value
//     busy       out 1         column in progress or result pending
//     res_valid  out 1         result available
//     res_ready  in  1         consumer accepts result
//     res_data   out NUM_SIZE  reduced value
//     res_count  out LEN_W     elements consumed
//     overflow   out 1         signed SUM overflow seen in this column
//
//   state   | meaning
//   --------+-------------------------------------------------
//   S_IDLE  | waiting for start; element strobes dropped
//   S_ACCUM | folding elements until len have been accepted
//   S_DONE  | result presented, held until res_ready
module column_reducer
  import column_reducer_pkg::*;
#(
  parameter int NUM_SIZE = NUM_SIZE_DEFAULT,
  parameter int LEN_W    = LEN_W_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [1:0]          agg_op,
  input  logic [LEN_W-1:0]    len,
  input  logic                in_valid,
  input  logic [NUM_SIZE-1:0] in_data,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [NUM_SIZE-1:0] res_data,
  output logic [LEN_W-1:0]    res_count,
  output logic                overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  agg_op_t             op_q, op_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic [NUM_SIZE-1:0] acc_q, acc_d;
  logic                ovf_q, ovf_d;

  logic [NUM_SIZE-1:0] step_acc;
  logic                step_ovf;
  logic [LEN_W-1:0]    cnt_inc;

  function automatic logic [NUM_SIZE-1:0] identity(input agg_op_t op);
    case (op)
      AGG_MIN: identity = {1'b0, {(NUM_SIZE-1){1'b1}}};
      AGG_MAX: identity = {1'b1, {(NUM_SIZE-1){1'b0}}};
      default: identity = '0;
    endcase
  endfunction

  column_reducer_reduce_step #(
    .NUM_SIZE (NUM_SIZE)
  ) u_reduce_step (
    .acc      (acc_q),
    .in_data  (in_data),
    .op       (op_q),
    .next_acc (step_acc),
    .ovf      (step_ovf)
  );

  assign cnt_inc = cnt_q + LEN_W'(1);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = agg_op_t'(agg_op);
          len_d   = len;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          acc_d   = identity(agg_op_t'(agg_op));
          state_d = (len == '0) ? S_DONE : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (in_valid) begin
          acc_d = step_acc;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | step_ovf;
          // cnt_inc == len is the same as cnt == len-1 without underflow.
          if (cnt_inc == len_q) state_d = S_DONE;
        end
      end
      S_DONE: begin
        // start is deliberately not looked at here, even on the handshake.
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= AGG_SUM;
      len_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign res_valid = (state_q == S_DONE);
  assign res_data  = acc_q;
  assign res_count = cnt_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_column_reducer.sv
module tb_column_reducer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  agg_op;
  logic [15:0] len;
  logic        in_valid;
  logic [31:0] in_data;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [15:0] res_count;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] data;
    logic [15:0] count;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  column_reducer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .agg_op    (agg_op),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_count (res_count),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Monitor: a result is consumed on a res_valid && res_ready cycle.
  always @(negedge clk) begin
    if (!reset && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got data 0x%08h with empty scoreboard", res_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("res_data", res_data, e.data);
        check("res_count", {16'h0, res_count}, {16'h0, e.count});
        check("overflow", {31'h0, overflow}, {31'h0, e.ovf});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [15:0] c, input logic o);
    exp_t e;
    e.data = d; e.count = c; e.ovf = o;
    sb.push_back(e);
  endtask

  task automatic do_start(input logic [1:0] op, input logic [15:0] l);
    start = 1'b1; agg_op = op; len = l;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [31:0] d);
    in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0; in_data = '0;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, {31'h0, busy}, 32'h0);
    check({tag, "_res_valid"}, {31'h0, res_valid}, 32'h0);
    check({tag, "_res_data"}, res_data, 32'h0);
    check({tag, "_res_count"}, {16'h0, res_count}, 32'h0);
    check({tag, "_overflow"}, {31'h0, overflow}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; agg_op = 2'd0; len = '0;
    in_valid = 1'b0; in_data = '0; res_ready = 1'b1;
    #12;
    check_zero_outputs("reset");
    tick();
    reset = 1'b0;
    tick();

    // SUM 1,2,3,4
    push(32'd10, 16'd4, 1'b0);
    do_start(2'd0, 16'd4);
    check("busy_after_start", {31'h0, busy}, 32'h1);
    beat(32'd1); beat(32'd2); beat(32'd3);
    check("sum_valid_early", {31'h0, res_valid}, 32'h0);
    beat(32'd4);
    check("sum_valid_after_last", {31'h0, res_valid}, 32'h1);
    tick();
    check("busy_after_handshake", {31'h0, busy}, 32'h0);

    // MIN / MAX with gaps: 5, -3, 7
    push(32'hFFFF_FFFD, 16'd3, 1'b0);
    do_start(2'd1, 16'd3);
    beat(32'd5); tick(); beat(32'hFFFF_FFFD); tick(); beat(32'd7);
    check("min_valid", {31'h0, res_valid}, 32'h1);
    tick();
    push(32'd7, 16'd3, 1'b0);
    do_start(2'd2, 16'd3);
    beat(32'd5); tick(); beat(32'hFFFF_FFFD); tick(); beat(32'd7);
    check("max_valid", {31'h0, res_valid}, 32'h1);
    tick();

    // MIN with len=0
    push(32'h7FFF_FFFF, 16'd0, 1'b0);
    do_start(2'd1, 16'd0);
    check("len0_valid", {31'h0, res_valid}, 32'h1);
    tick();

    // SUM overflow
    push(32'h8000_0000, 16'd2, 1'b1);
    do_start(2'd0, 16'd2);
    beat(32'h7FFF_FFFF); beat(32'd1);
    check("ovf_valid", {31'h0, res_valid}, 32'h1);
    tick();

    // COUNT_NZ 0,3,0,9; next column's overflow must have been cleared
    push(32'd2, 16'd4, 1'b0);
    do_start(2'd3, 16'd4);
    check("ovf_cleared", {31'h0, overflow}, 32'h0);
    beat(32'd0); beat(32'd3); beat(32'd0); beat(32'd9);
    check("cnt_valid", {31'h0, res_valid}, 32'h1);
    tick();

    // Backpressure: SUM 5,6 held while inputs toggle
    res_ready = 1'b0;
    push(32'd11, 16'd2, 1'b0);
    do_start(2'd0, 16'd2);
    beat(32'd5); beat(32'd6);
    for (int i = 0; i < 5; i++) begin
      start = 1'b1; agg_op = 2'd2; len = 16'd1;
      in_valid = 1'b1; in_data = 32'd100;
      tick();
      check("bp_valid", {31'h0, res_valid}, 32'h1);
      check("bp_data", res_data, 32'd11);
      check("bp_count", {16'h0, res_count}, 32'd2);
    end
    // start still high on the handshake cycle must be ignored
    res_ready = 1'b1;
    tick();
    start = 1'b0; in_valid = 1'b0; in_data = '0;
    check("bp_idle_busy", {31'h0, busy}, 32'h0);
    check("bp_idle_valid", {31'h0, res_valid}, 32'h0);
    push(32'd42, 16'd1, 1'b0);
    do_start(2'd0, 16'd1);
    beat(32'd42);
    check("bp_new_valid", {31'h0, res_valid}, 32'h1);
    tick();

    // Reset in the middle of a column
    do_start(2'd0, 16'd4);
    beat(32'd1); beat(32'd2);
    reset = 1'b1;
    #1;
    check_zero_outputs("midreset");
    tick();
    reset = 1'b0;
    tick();
    push(32'd9, 16'd1, 1'b0);
    do_start(2'd0, 16'd1);
    beat(32'd9);
    check("post_reset_valid", {31'h0, res_valid}, 32'h1);
    tick();
    tick();

    check("scoreboard_drained", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/column_reducer.md
# column_reducer

Aggregation stage directly downstream of the element-wise ALU. It consumes the ALU's `out`/`valid` result stream and reduces one column of `len` results to a single scalar: SUM, MIN, MAX or COUNT of non-zero elements. It holds the scalar behind a valid/ready handshake until the host-side result path accepts it. This gives the pandas-style `sum()`/`min()`/`max()`/`count()` over a computed column without returning every element to the PS.

## Interface
Parameters:
- `NUM_SIZE`, default `NUM_SIZE` from `def.svh` (32): data width, signed two's complement.
- `LEN_W`, default 16: element-count width; must be ≤ `NUM_SIZE`.

Ports:
- `clk`  input  1  clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `start`  input  1  single-cycle request; latches `agg_op` and `len`. Accepted only in IDLE.
- `agg_op`  input  2  0=SUM, 1=MIN, 2=MAX, 3=COUNT_NZ.
- `len`  input  LEN_W  number of elements to reduce.
- `in_valid`  input  1  ALU `valid`; one element per cycle when high.
- `in_data`  input  NUM_SIZE  ALU `out`.
- `busy`  output  1  high in ACCUM and DONE.
- `res_valid`  output  1  result available.
- `res_ready`  input  1  consumer accepts the result.
- `res_data`  output  NUM_SIZE  reduced value.
- `res_count`  output  LEN_W  number of elements consumed.
- `overflow`  output  1  a signed SUM overflow occurred during this column.

## Operation
- States are IDLE, ACCUM and DONE.
- **IDLE.** On `start`, latch op and len, clear `cnt` and `overflow`, and load `acc` with the op's identity:
  - SUM: 0
  - MIN: `2^(NUM_SIZE-1)-1`
  - MAX: `-2^(NUM_SIZE-1)`
  - COUNT_NZ: 0
  - If `len==0`, go to DONE with `acc` = identity. Otherwise go to ACCUM.
- **ACCUM.** Each cycle with `in_valid`, update `acc` and increment `cnt`:
  - SUM: `acc+in_data` wraps modulo 2^NUM_SIZE. `overflow` is sticky-set when the operand signs are equal and the result sign differs.
  - MIN/MAX: signed compare.
  - COUNT_NZ: `acc+1` when `in_data!=0`. The result is zero-extended.
  - When the accepted beat is number `len` (`cnt==len-1` and `in_valid`), go to DONE.
  - Gaps in `in_valid` are allowed and do not count.
- **DONE.** `res_valid=1`. `res_data`, `res_count` and `overflow` are held stable until `res_ready`. On a `res_valid && res_ready` cycle, go to IDLE.
- Ignored inputs:
  - `in_valid` in IDLE or DONE is dropped.
  - `start` in ACCUM or DONE is ignored, including on the DONE handshake cycle. The earliest new start is the cycle after the handshake.
- **Reset** (asynchronous, any state): go to IDLE. `acc`, `cnt`, `busy`, `res_valid`, `res_data`, `res_count` and `overflow` all become 0. A column in flight is discarded.

## Timing
- `busy` rises the cycle after `start` is accepted.
- `res_valid` rises the cycle after the `len`th accepted beat. For `len==0`, it rises the cycle after `start`.
- Result latency from the last beat is 1 cycle. Minimum column time is `len+1` cycles with back-to-back `in_valid`.
- `res_data` equals `acc` and is registered. There are no combinational paths from inputs to outputs.
- `res_valid` falls, and `busy` falls, the cycle after the handshake.

## Structure
- Add `agg_op_t` (2-bit enum: `AGG_SUM`, `AGG_MIN`, `AGG_MAX`, `AGG_CNT`) and the identity constants to `def.svh`.
- Add a `state_t` enum, local to this module.
- One natural sub-module: `reduce_step`. It is combinational, takes `(acc, in_data, op)` and returns `(next_acc, ovf)`, and is reusable by future group-by stages.
- Connect the ALU through the existing interface: `in_data` ← `out`, `in_valid` ← `valid`.

## Test plan
- SUM, len=4, beats 1,2,3,4 back-to-back → `res_data`=10, `res_count`=4, `overflow`=0; `res_valid` high the cycle after beat 4.
- MIN then MAX, len=3, beats 5, 0xFFFFFFFD, 7 with one idle cycle between beats → MIN = 0xFFFFFFFD, MAX = 7, `res_count`=3.
- MIN with len=0 → `res_valid` the cycle after `start`, `res_data`=0x7FFFFFFF, `res_count`=0.
- SUM, len=2, beats 0x7FFFFFFF, 1 → `res_data`=0x80000000, `overflow`=1. COUNT_NZ over 0,3,0,9 → 2.
- Backpressure: hold `res_ready`=0 for 5 cycles while pulsing `in_valid` and `start` → outputs stable and inputs ignored. Then `res_ready`=1 → IDLE next cycle, and a new `start` is accepted after that.
- Reset asserted after 2 of 4 SUM beats → all outputs 0 immediately. A following `start` (SUM, len=1, beat 9) → `res_data`=9.
